// File: rtl/canden_dyn_ctrl.sv
// canden_dyn_ctrl
//   Dynamic enable controller placed directly upstream of the CANDEN clock-gate
//   cell. It collects clock-on requests from NREQ consumers and drives
//   CANDEN's DYNEN and DEN inputs. Once DYNEN has been high for WAKE_CYC edges,
//   each requester gets an ACK, which means its gated clock is running and
//   stable. After the last request drops, the clock is held for IDLE_CYC
//   edges and then gated off.
//
// Ports
//   CLKIN    in   free-running source clock; all logic on the rising edge
//   RST      in   asynchronous, active-high reset
//   REQ      in   [NREQ] per-requester level request
//   FORCE_ON in   keeps the gated clock on; never produces an ACK
//   ACK      out  [NREQ] per-requester grant, registered
//   DYNEN    out  dynamic enable to CANDEN, registered
//   DEN      out  dynamic-mode select to CANDEN, registered
//   BUSY     out  high whenever the controller is not in OFF
module canden_dyn_ctrl #(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int CW       = 4
) (
    input  logic            CLKIN,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic            FORCE_ON,
    output logic [NREQ-1:0] ACK,
    output logic            DYNEN,
    output logic            DEN,
    output logic            BUSY
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_WAKE  = 2'd1;
    localparam logic [1:0] S_ON    = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYC);
    localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYC);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          any_req;

    assign any_req = (|REQ) | FORCE_ON;

    // BUSY decodes the state register only, so no input reaches it combinationally.
    assign BUSY = (state != S_OFF);

    always_ff @(posedge CLKIN or posedge RST) begin
        if (RST) begin
            state <= S_OFF;
            cnt   <= '0;
            DYNEN <= 1'b0;
            ACK   <= '0;
            DEN   <= 1'b0;
        end else begin
            // Dynamic mode is selected from the first edge after reset onwards.
            DEN <= 1'b1;
            case (state)
                S_OFF: begin
                    ACK <= '0;
                    if (any_req) begin
                        state <= S_WAKE;
                        DYNEN <= 1'b1;
                        cnt   <= WAKE_LD;
                    end
                end
                S_WAKE: begin
                    // Runs to completion even if every request has gone away;
                    // a request present on the final edge is granted right away.
                    if (cnt == CNT_ONE) begin
                        state <= S_ON;
                        ACK   <= REQ;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        ACK <= '0;
                    end
                end
                S_ON: begin
                    if (!any_req) begin
                        state <= S_DRAIN;
                        cnt   <= IDLE_LD;
                        ACK   <= '0;
                    end else begin
                        ACK <= REQ;
                    end
                end
                S_DRAIN: begin
                    // The clock never stopped, so a returning request skips the
                    // wake delay; it also beats the final idle edge.
                    if (any_req) begin
                        state <= S_ON;
                        ACK   <= REQ;
                    end else if (cnt == CNT_ONE) begin
                        state <= S_OFF;
                        DYNEN <= 1'b0;
                        ACK   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        ACK <= '0;
                    end
                end
                default: begin
                    state <= S_OFF;
                    DYNEN <= 1'b0;
                    ACK   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canden_dyn_ctrl.sv
module tb_canden_dyn_ctrl;

    localparam int NREQ     = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 8;
    localparam int CW       = 4;

    logic            CLKIN;
    logic            RST;
    logic [NREQ-1:0] REQ;
    logic            FORCE_ON;
    logic [NREQ-1:0] ACK;
    logic            DYNEN;
    logic            DEN;
    logic            BUSY;

    int n_checks = 0;
    int n_errors = 0;

    canden_dyn_ctrl #(
        .NREQ(NREQ), .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC), .CW(CW)
    ) dut (
        .CLKIN(CLKIN), .RST(RST), .REQ(REQ), .FORCE_ON(FORCE_ON),
        .ACK(ACK), .DYNEN(DYNEN), .DEN(DEN), .BUSY(BUSY)
    );

    initial begin
        CLKIN = 1'b0;
        forever #5 CLKIN = ~CLKIN;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLKIN);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        REQ = '0;
        FORCE_ON = 1'b0;

        // Reset / idle
        tick();
        tick();
        check_eq("rst_dynen", 32'(DYNEN), 32'd0);
        check_eq("rst_ack",   32'(ACK),   32'd0);
        check_eq("rst_busy",  32'(BUSY),  32'd0);
        check_eq("rst_den",   32'(DEN),   32'd0);
        RST = 1'b0;
        tick();
        check_eq("den_after_rst", 32'(DEN), 32'd1);
        for (int i = 0; i < 20; i++) tick();
        check_eq("idle_dynen", 32'(DYNEN), 32'd0);
        check_eq("idle_ack",   32'(ACK),   32'd0);
        check_eq("idle_busy",  32'(BUSY),  32'd0);
        check_eq("idle_den",   32'(DEN),   32'd1);

        // Single request: DYNEN at edge 0, ACK at edge 2, off at edge 18
        REQ = 4'b0001;
        tick();
        check_eq("single_e0_dynen", 32'(DYNEN), 32'd1);
        check_eq("single_e0_ack",   32'(ACK),   32'd0);
        check_eq("single_e0_busy",  32'(BUSY),  32'd1);
        tick();
        check_eq("single_e1_ack", 32'(ACK), 32'd0);
        tick();
        check_eq("single_e2_ack", 32'(ACK), 32'd1);
        for (int e = 3; e <= 9; e++) tick();
        check_eq("single_e9_ack", 32'(ACK), 32'd1);
        REQ = 4'b0000;
        tick();
        check_eq("single_e10_ack",   32'(ACK),   32'd0);
        check_eq("single_e10_dynen", 32'(DYNEN), 32'd1);
        for (int e = 11; e <= 17; e++) begin
            tick();
            check_eq("single_drain_dynen", 32'(DYNEN), 32'd1);
        end
        tick();
        check_eq("single_e18_dynen", 32'(DYNEN), 32'd0);
        check_eq("single_e18_busy",  32'(BUSY),  32'd0);

        // Multi-requester: ACK follows REQ one edge later
        REQ = 4'b0001;
        for (int e = 0; e <= 8; e++) begin
            logic [3:0] exp_ack;
            if (e == 5) REQ = 4'b0011;
            if (e == 8) REQ = 4'b0010;
            tick();
            if (e < 2)      exp_ack = 4'b0000;
            else if (e < 5) exp_ack = 4'b0001;
            else if (e < 8) exp_ack = 4'b0011;
            else            exp_ack = 4'b0010;
            check_eq("multi_ack",   32'(ACK),   32'(exp_ack));
            check_eq("multi_dynen", 32'(DYNEN), 32'd1);
        end
        REQ = 4'b0000;
        for (int i = 0; i < IDLE_CYC + 1; i++) tick();
        check_eq("multi_off_dynen", 32'(DYNEN), 32'd0);

        // DRAIN rescue on the last idle edge
        REQ = 4'b0001;
        tick(); tick(); tick();
        check_eq("rescue_on_ack", 32'(ACK), 32'd1);
        REQ = 4'b0000;
        for (int k = 0; k < IDLE_CYC; k++) begin
            tick();
            check_eq("rescue_drain_dynen", 32'(DYNEN), 32'd1);
            check_eq("rescue_drain_ack",   32'(ACK),   32'd0);
        end
        REQ = 4'b0100;
        tick();
        check_eq("rescue_ack",   32'(ACK),   32'd4);
        check_eq("rescue_dynen", 32'(DYNEN), 32'd1);
        tick();
        check_eq("rescue_hold_ack", 32'(ACK), 32'd4);
        REQ = 4'b0000;
        for (int i = 0; i < IDLE_CYC + 1; i++) tick();
        check_eq("rescue_off_dynen", 32'(DYNEN), 32'd0);

        // FORCE_ON keeps the clock without any ACK
        FORCE_ON = 1'b1;
        tick();
        check_eq("force_e0_dynen", 32'(DYNEN), 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            check_eq("force_ack", 32'(ACK), 32'd0);
        end
        check_eq("force_dynen", 32'(DYNEN), 32'd1);
        check_eq("force_busy",  32'(BUSY),  32'd1);
        FORCE_ON = 1'b0;
        for (int i = 0; i < IDLE_CYC; i++) begin
            tick();
            check_eq("force_drain_dynen", 32'(DYNEN), 32'd1);
        end
        tick();
        check_eq("force_off_dynen", 32'(DYNEN), 32'd0);

        // Asynchronous reset during WAKE
        REQ = 4'b0001;
        tick();
        check_eq("awake_dynen_pre", 32'(DYNEN), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_eq("awake_rst_dynen", 32'(DYNEN), 32'd0);
        check_eq("awake_rst_ack",   32'(ACK),   32'd0);
        check_eq("awake_rst_busy",  32'(BUSY),  32'd0);
        check_eq("awake_rst_den",   32'(DEN),   32'd0);
        #2 RST = 1'b0;
        tick();
        check_eq("awake_re_e0_dynen", 32'(DYNEN), 32'd1);
        check_eq("awake_re_e0_ack",   32'(ACK),   32'd0);
        check_eq("awake_re_den",      32'(DEN),   32'd1);
        tick();
        check_eq("awake_re_e1_ack", 32'(ACK), 32'd0);
        tick();
        check_eq("awake_re_e2_ack", 32'(ACK), 32'd1);

        // Asynchronous reset during ON
        #2 RST = 1'b1;
        #1;
        check_eq("aon_rst_dynen", 32'(DYNEN), 32'd0);
        check_eq("aon_rst_ack",   32'(ACK),   32'd0);
        check_eq("aon_rst_busy",  32'(BUSY),  32'd0);
        #2 RST = 1'b0;
        REQ = 4'b1000;
        tick();
        check_eq("aon_re_e0_dynen", 32'(DYNEN), 32'd1);
        check_eq("aon_re_e0_ack",   32'(ACK),   32'd0);
        tick();
        check_eq("aon_re_e1_ack", 32'(ACK), 32'd0);
        tick();
        check_eq("aon_re_e2_ack", 32'(ACK), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
